// File: rtl/perf_monitor_window_ctrl.sv
// Measurement-window controller for the bus performance monitor: arms the latency
// datapath for a programmed window, accumulates count/sum/min/max, drains, holds results.
module perf_monitor_window_ctrl #(
  parameter int LAT_WIDTH    = 31,
  parameter int CNT_WIDTH    = 32,
  parameter int SUM_WIDTH    = 48,
  parameter int DRAIN_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [CNT_WIDTH-1:0] window_len_i,
  input  logic [CNT_WIDTH-1:0] max_samples_i,
  output logic                 mon_en_o,
  output logic                 mon_flush_o,
  input  logic                 mon_busy_i,
  input  logic                 sample_valid_i,
  input  logic [LAT_WIDTH-1:0] sample_data_i,
  output logic                 sample_ready_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic [SUM_WIDTH-1:0] sum_o,
  output logic [LAT_WIDTH-1:0] min_o,
  output logic [LAT_WIDTH-1:0] max_o,
  output logic [2:0]           err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_MEASURE, S_DRAIN, S_DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [31:0]          DRAIN_LAST = 32'(DRAIN_CYCLES - 1);

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   win_len, max_samp, win_cnt, count;
  logic [31:0]            drain_cnt;
  logic [SUM_WIDTH-1:0]   sum;
  logic [LAT_WIDTH-1:0]   min_lat, max_lat;
  logic [2:0]             err;
  logic                   hs, accept, win_hit, limit_hit, set_abort, set_timeout;
  logic [SUM_WIDTH:0]     sum_add;

  // A sample transfers when sample_valid_i and sample_ready_o are both high at a
  // rising edge; ready is a pure state decode and never looks at valid.
  assign sample_ready_o = (state != S_CLEAR);
  assign mon_en_o       = (state == S_MEASURE);
  assign mon_flush_o    = (state == S_CLEAR);
  assign busy_o         = (state == S_CLEAR) || (state == S_MEASURE) || (state == S_DRAIN);
  assign done_o         = (state == S_DONE);
  assign count_o        = count;
  assign sum_o          = sum;
  assign min_o          = min_lat;
  assign max_o          = max_lat;
  assign err_o          = err;

  assign hs        = sample_valid_i && sample_ready_o;
  assign accept    = hs && ((state == S_MEASURE) || (state == S_DRAIN)) &&
                     ((max_samp == '0) || (count < max_samp));
  assign win_hit   = (win_len != '0) && (win_cnt == win_len - CNT_ONE);
  // The limit counts the sample being accepted this very cycle.
  assign limit_hit = (max_samp != '0) &&
                     ((count >= max_samp) || (accept && (count + CNT_ONE == max_samp)));
  assign sum_add   = {1'b0, sum} + {{(SUM_WIDTH + 1 - LAT_WIDTH){1'b0}}, sample_data_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    set_abort   = 1'b0;
    set_timeout = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_i && !abort_i) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        if (abort_i) begin
          state_nxt = S_DONE;
          set_abort = 1'b1;
        end else begin
          state_nxt = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (abort_i) begin
          state_nxt = S_DONE;
          set_abort = 1'b1;
        end else if (win_hit || limit_hit) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort_i) begin
          state_nxt = S_DONE;
          set_abort = 1'b1;
        end else if (!mon_busy_i && !sample_valid_i) begin
          state_nxt = S_DONE;
        end else if (drain_cnt == DRAIN_LAST) begin
          state_nxt   = S_DONE;
          set_timeout = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_len   <= '0;
      max_samp  <= '0;
      win_cnt   <= '0;
      drain_cnt <= '0;
      count     <= '0;
      sum       <= '0;
      min_lat   <= '1;
      max_lat   <= '0;
      err       <= '0;
    end else if (state == S_CLEAR) begin
      win_len   <= window_len_i;
      max_samp  <= max_samples_i;
      win_cnt   <= '0;
      drain_cnt <= '0;
      count     <= '0;
      sum       <= '0;
      min_lat   <= '1;
      max_lat   <= '0;
      err       <= {set_abort, 2'b00};
    end else begin
      if (state == S_MEASURE) win_cnt <= win_cnt + CNT_ONE;
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 32'd1 : 32'd0;
      if (accept) begin
        if (count != '1) count <= count + CNT_ONE;
        if (sum_add[SUM_WIDTH]) begin
          sum    <= '1;
          err[0] <= 1'b1;
        end else begin
          sum <= sum_add[SUM_WIDTH-1:0];
        end
        if (sample_data_i < min_lat) min_lat <= sample_data_i;
        if (sample_data_i > max_lat) max_lat <= sample_data_i;
      end
      if (set_abort)   err[2] <= 1'b1;
      if (set_timeout) err[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_perf_monitor_window_ctrl.sv
// Directed bench for perf_monitor_window_ctrl: window, limit, drain timeout, abort,
// sum saturation and asynchronous reset, each with hand-computed expectations.
module tb_perf_monitor_window_ctrl;

  localparam int LW = 31;
  localparam int CW = 32;
  localparam int SW = 32;
  localparam int DC = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, mon_busy, sample_valid;
  logic [CW-1:0] window_len, max_samples;
  logic [LW-1:0] sample_data;
  logic          mon_en, mon_flush, sample_ready, busy, done;
  logic [CW-1:0] count;
  logic [SW-1:0] sum;
  logic [LW-1:0] min_v, max_v;
  logic [2:0]    err;

  int checks = 0;
  int errors = 0;

  localparam logic [LW-1:0] LAT_ONES = '1;
  localparam logic [SW-1:0] SUM_ONES = '1;

  always #5 clk = ~clk;

  perf_monitor_window_ctrl #(
    .LAT_WIDTH(LW), .CNT_WIDTH(CW), .SUM_WIDTH(SW), .DRAIN_CYCLES(DC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .window_len_i(window_len), .max_samples_i(max_samples),
    .mon_en_o(mon_en), .mon_flush_o(mon_flush), .mon_busy_i(mon_busy),
    .sample_valid_i(sample_valid), .sample_data_i(sample_data),
    .sample_ready_o(sample_ready), .busy_o(busy), .done_o(done),
    .count_o(count), .sum_o(sum), .min_o(min_v), .max_o(max_v), .err_o(err)
  );

  // Drives a one-cycle start; returns at the negedge where the block sits in CLEAR.
  task automatic do_start(input logic [CW-1:0] len, input logic [CW-1:0] maxs);
    window_len  = len;
    max_samples = maxs;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (mon_en !== 1'b0)     begin errors++; $display("FAIL reset_mon_en got %0b exp 0", mon_en); end
    checks++; if (mon_flush !== 1'b0)  begin errors++; $display("FAIL reset_flush got %0b exp 0", mon_flush); end
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", sample_ready); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got %b exp 00", {busy, done}); end
    checks++; if (min_v !== LAT_ONES)  begin errors++; $display("FAIL reset_min got %h exp %h", min_v, LAT_ONES); end
    checks++; if ({count, sum, max_v, err} !== '0) begin errors++; $display("FAIL reset_zero got cnt %0d sum %0d max %0d err %b exp all 0", count, sum, max_v, err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fixed_window;
    int en_cnt = 0;
    do_start(10, 0);
    checks++; if (mon_flush !== 1'b1 || sample_ready !== 1'b0) begin errors++; $display("FAIL clear_flush_ready got %b%b exp 10", mon_flush, sample_ready); end
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      if (mon_en) en_cnt++;
      sample_valid = (i == 1) || (i == 4) || (i == 7);
      sample_data  = (i == 1) ? 31'd5 : (i == 4) ? 31'd7 : 31'd3;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    checks++; if (en_cnt != 10) begin errors++; $display("FAIL window_en_cycles got %0d exp 10", en_cnt); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL window_done got done %b busy %b exp 1 0", done, busy); end
    checks++; if (count !== 32'd3) begin errors++; $display("FAIL window_count got %0d exp 3", count); end
    checks++; if (sum !== 32'd15) begin errors++; $display("FAIL window_sum got %0d exp 15", sum); end
    checks++; if (min_v !== 31'd3 || max_v !== 31'd7) begin errors++; $display("FAIL window_minmax got %0d %0d exp 3 7", min_v, max_v); end
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL window_err got %b exp 000", err); end
  endtask

  task automatic test_sample_limit;
    do_start(0, 2);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = 31'd4;
    @(negedge clk);
    sample_data  = 31'd9;
    @(negedge clk);
    checks++; if (mon_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL limit_drain got en %b busy %b exp 0 1", mon_en, busy); end
    sample_data = 31'd6;
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL limit_ready got %b exp 1", sample_ready); end
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL limit_done got %b exp 1", done); end
    checks++; if (count !== 32'd2 || sum !== 32'd13) begin errors++; $display("FAIL limit_count_sum got %0d %0d exp 2 13", count, sum); end
    checks++; if (min_v !== 31'd4 || max_v !== 31'd9) begin errors++; $display("FAIL limit_minmax got %0d %0d exp 4 9", min_v, max_v); end
  endtask

  task automatic test_drain_timeout;
    int n = 0;
    mon_busy = 1'b1;
    do_start(3, 0);
    repeat (4) @(negedge clk);
    checks++; if (mon_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_drain_entry got en %b busy %b exp 0 1", mon_en, busy); end
    for (int i = 1; i <= DC + 5; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
    checks++; if (n != DC) begin errors++; $display("FAIL timeout_latency got %0d exp %0d", n, DC); end
    checks++; if (err !== 3'b010) begin errors++; $display("FAIL timeout_err got %b exp 010", err); end
    mon_busy = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort;
    do_start(0, 0);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = 31'd10;
    @(negedge clk);
    sample_data  = 31'd20;
    @(negedge clk);
    sample_valid = 1'b0;
    abort        = 1'b1;
    @(negedge clk);
    abort        = 1'b0;
    checks++; if (done !== 1'b1 || err !== 3'b100) begin errors++; $display("FAIL abort_done got done %b err %b exp 1 100", done, err); end
    checks++; if (count !== 32'd2 || sum !== 32'd30) begin errors++; $display("FAIL abort_partial got %0d %0d exp 2 30", count, sum); end
    checks++; if (min_v !== 31'd10 || max_v !== 31'd20) begin errors++; $display("FAIL abort_minmax got %0d %0d exp 10 20", min_v, max_v); end
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || mon_flush !== 1'b0) begin errors++; $display("FAIL abort_start_same got done %b busy %b flush %b exp 1 0 0", done, busy, mon_flush); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || count !== 32'd2 || err !== 3'b100) begin errors++; $display("FAIL abort_held got done %b cnt %0d err %b exp 1 2 100", done, count, err); end
  endtask

  task automatic test_saturation;
    do_start(4, 0);
    checks++; if (count !== 32'd2) begin errors++; $display("FAIL sat_clear_timing got %0d exp 2", count); end
    @(negedge clk);
    checks++; if (count !== 32'd0 || err !== 3'b000 || min_v !== LAT_ONES) begin errors++; $display("FAIL sat_cleared got cnt %0d err %b min %h exp 0 000 all-ones", count, err, min_v); end
    sample_valid = 1'b1;
    sample_data  = LAT_ONES;
    @(negedge clk);
    @(negedge clk);
    checks++; if (sum !== 32'hFFFF_FFFE || err !== 3'b000) begin errors++; $display("FAIL sat_two got sum %h err %b exp fffffffe 000", sum, err); end
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sum !== SUM_ONES || err !== 3'b001) begin errors++; $display("FAIL sat_sum got sum %h err %b exp ffffffff 001", sum, err); end
    checks++; if (done !== 1'b1 || count !== 32'd3) begin errors++; $display("FAIL sat_done got done %b cnt %0d exp 1 3", done, count); end
  endtask

  task automatic test_reset_mid_drain;
    mon_busy = 1'b1;
    do_start(2, 0);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = 31'd8;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1 || mon_en !== 1'b0 || count !== 32'd1) begin errors++; $display("FAIL rst_pre_drain got busy %b en %b cnt %0d exp 1 0 1", busy, mon_en, count); end
    rst_n = 1'b0;
    #1;
    checks++; if ({mon_en, mon_flush, busy, done, sample_ready} !== 5'b00001) begin errors++; $display("FAIL rst_mid_ctrl got %b exp 00001", {mon_en, mon_flush, busy, done, sample_ready}); end
    checks++; if ({count, sum, max_v, err} !== '0 || min_v !== LAT_ONES) begin errors++; $display("FAIL rst_mid_results got cnt %0d sum %0d max %0d err %b min %h exp 0 0 0 000 all-ones", count, sum, max_v, err, min_v); end
    mon_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_release got busy %b done %b exp 0 0", busy, done); end
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    mon_busy     = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    window_len   = '0;
    max_samples  = '0;
    test_reset();
    test_fixed_window();
    test_sample_limit();
    test_drain_timeout();
    test_abort();
    test_saturation();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
